// File: rtl/pp_fifo.sv
// Elastic rdy/ack buffer between pipeline stages.
// src_ack depends only on src_rdy and registered state, so there is no combinational path from dst_ack.
module pp_fifo #(
    parameter int BW    = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          src_rdy,
    input  logic [BW-1:0] src_dat,
    output logic          src_ack,
    output logic          dst_rdy,
    output logic [BW-1:0] dst_dat,
    input  logic          dst_ack,
    output logic [LW-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [BW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;

    // Handshake decode and next level; full/empty come from the level count, not from pointers
    always_comb begin
        w_full      = (r_level == LW'(DEPTH));
        w_empty     = (r_level == {LW{1'b0}});
        w_push      = src_rdy & ~w_full & rst_n;
        w_pop       = ~w_empty & dst_ack;
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointer and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_level <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_level <= w_level_nxt;
        end
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= src_dat;
        end
    end

    assign src_ack = w_push;
    assign dst_rdy = ~w_empty;
    assign dst_dat = r_mem[r_rptr];
    assign level   = r_level;

endmodule

// File: tb/tb_pp_fifo.sv
// Directed and constrained-random checks of pp_fifo with hand-computed expectations and a queue model.
module tb_pp_fifo;

    localparam int BW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          src_rdy = 1'b0;
    logic [BW-1:0] src_dat = 8'h00;
    logic          dst_ack = 1'b0;
    logic          src_ack;
    logic          dst_rdy;
    logic [BW-1:0] dst_dat;
    logic [LW-1:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    pp_fifo #(.BW(BW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_rdy (src_rdy),
        .src_dat (src_dat),
        .src_ack (src_ack),
        .dst_rdy (dst_rdy),
        .dst_dat (dst_dat),
        .dst_ack (dst_ack),
        .level   (level)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n   = 1'b0;
        src_rdy = 1'b1;
        src_dat = 8'h11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (src_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_src_ack_gated: got %b want 0", src_ack);
        end
        n_tests++;
        if (dst_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dst_rdy: got %b want 0", dst_rdy);
        end
        src_rdy = 1'b0;
        rst_n   = 1'b1;
        #1;
        n_tests++;
        if (level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_level: got %0d want 0", level);
        end
        n_tests++;
        if (src_ack !== 1'b0 || dst_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got src_ack=%b dst_rdy=%b want 0 0", src_ack, dst_rdy);
        end
        // dst_ack while empty must be ignored
        dst_ack = 1'b1;
        @(negedge clk);
        dst_ack = 1'b0;
        #1;
        n_tests++;
        if (level !== 3'd0 || dst_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_ack_ignored: got level=%0d dst_rdy=%b want 0 0", level, dst_rdy);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        src_rdy = 1'b1;
        src_dat = 8'h5A;
        dst_ack = 1'b0;
        #1;
        n_tests++;
        if (src_ack !== 1'b1 || dst_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: got src_ack=%b dst_rdy=%b want 1 0", src_ack, dst_rdy);
        end
        @(negedge clk);
        src_rdy = 1'b0;
        src_dat = 8'hFF;
        #1;
        n_tests++;
        if (dst_rdy !== 1'b1 || dst_dat !== 8'h5A || level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_visible: got rdy=%b dat=%h lvl=%0d want 1 5a 1", dst_rdy, dst_dat, level);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (dst_rdy !== 1'b1 || dst_dat !== 8'h5A) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: got rdy=%b dat=%h want 1 5a", i, dst_rdy, dst_dat);
            end
        end
        dst_ack = 1'b1;
        @(negedge clk);
        dst_ack = 1'b0;
        #1;
        n_tests++;
        if (level !== 3'd0 || dst_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got level=%0d dst_rdy=%b want 0 0", level, dst_rdy);
        end
    endtask

    task automatic test_fill();
        logic [BW-1:0] exp_dat [5];
        logic [LW-1:0] exp_lvl [5];
        logic          exp_ack [5];
        logic          off_rdy [5];
        exp_dat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_lvl = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        off_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        dst_ack = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            src_rdy = 1'b1;
            src_dat = BW'(i);
            #1;
            n_tests++;
            if (src_ack !== (i <= DEPTH)) begin
                n_fail++;
                $display("FAIL fill_ack[%0d]: got %b want %b", i, src_ack, (i <= DEPTH));
            end
        end
        // Drain while 0x05 keeps being offered; it enters only after the first pop
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            src_rdy = off_rdy[i];
            src_dat = 8'h05;
            dst_ack = 1'b1;
            #1;
            n_tests++;
            if (dst_dat !== exp_dat[i] || level !== exp_lvl[i] || src_ack !== exp_ack[i]) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: got dat=%h lvl=%0d ack=%b want %h %0d %b",
                         i, dst_dat, level, src_ack, exp_dat[i], exp_lvl[i], exp_ack[i]);
            end
        end
        @(negedge clk);
        dst_ack = 1'b0;
        #1;
        n_tests++;
        if (dst_rdy !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_empty: got rdy=%b lvl=%0d want 0 0", dst_rdy, level);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            src_rdy = 1'b1;
            src_dat = BW'(i);
            dst_ack = 1'b1;
            #1;
            n_tests++;
            if (src_ack !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_src_ack[%0d]: got %b want 1", i, src_ack);
            end
            if (i > 0) begin
                n_tests++;
                if (dst_rdy !== 1'b1 || dst_dat !== BW'(i - 1) || level !== 3'd1) begin
                    n_fail++;
                    $display("FAIL stream_out[%0d]: got rdy=%b dat=%h lvl=%0d want 1 %h 1",
                             i, dst_rdy, dst_dat, level, BW'(i - 1));
                end
            end
        end
        @(negedge clk);
        src_rdy = 1'b0;
        #1;
        n_tests++;
        if (dst_dat !== 8'd99 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL stream_last: got dat=%h lvl=%0d want 63 1", dst_dat, level);
        end
        @(negedge clk);
        dst_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [BW-1:0] q[$];
        int  sent   = 0;
        int  recv   = 0;
        int  cycles = 0;
        int  p;
        bit  push_m;
        bit  pop_m;
        while (recv < 1000 && cycles < 20000) begin
            @(negedge clk);
            p       = (recv < 500) ? 200 : 50;
            src_rdy = (sent < 1000) && ($urandom_range(0, 255) < p);
            src_dat = src_rdy ? BW'(sent * 7 + 3) : BW'($urandom_range(0, 255));
            dst_ack = ($urandom_range(0, 255) < p);
            #1;
            push_m = src_rdy && (q.size() < DEPTH);
            pop_m  = (q.size() != 0) && dst_ack;
            n_tests++;
            if (src_ack !== push_m || dst_rdy !== (q.size() != 0) || level !== LW'(q.size())) begin
                n_fail++;
                $display("FAIL random_ctl[%0d]: got ack=%b rdy=%b lvl=%0d want %b %b %0d",
                         cycles, src_ack, dst_rdy, level, push_m, (q.size() != 0), q.size());
            end
            if (q.size() != 0) begin
                n_tests++;
                if (dst_dat !== q[0]) begin
                    n_fail++;
                    $display("FAIL random_data[%0d]: got %h want %h", recv, dst_dat, q[0]);
                end
            end
            @(posedge clk);
            if (pop_m) begin
                void'(q.pop_front());
                recv++;
            end
            if (push_m) begin
                q.push_back(src_dat);
                sent++;
            end
            cycles++;
        end
        n_tests++;
        if (recv != 1000) begin
            n_fail++;
            $display("FAIL random_timeout: got %0d words want 1000", recv);
        end
        @(negedge clk);
        src_rdy = 1'b0;
        dst_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            src_rdy = 1'b1;
            src_dat = BW'(8'hC0 + i);
        end
        @(negedge clk);
        src_rdy = 1'b1;
        src_dat = 8'h77;
        #1;
        n_tests++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL midrst_level_before: got %0d want 3", level);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dst_rdy !== 1'b0 || level !== 3'd0 || src_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got rdy=%b lvl=%0d ack=%b want 0 0 0", dst_rdy, level, src_ack);
        end
        @(negedge clk);
        src_rdy = 1'b1;
        src_dat = 8'hA5;
        rst_n   = 1'b1;
        #1;
        n_tests++;
        if (src_ack !== 1'b1 || dst_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_accept: got ack=%b rdy=%b want 1 0", src_ack, dst_rdy);
        end
        @(negedge clk);
        src_rdy = 1'b0;
        #1;
        n_tests++;
        if (dst_rdy !== 1'b1 || dst_dat !== 8'hA5 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL midrst_first: got rdy=%b dat=%h lvl=%0d want 1 a5 1", dst_rdy, dst_dat, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
